urom_rd_adapter: RTL

Data-bus read port for the instruction/constant ROM: accepts byte-addressed load requests from the core's load/store unit, drives the ROM's clock-enabled word read port (CE, word address), waits for the ROM's valid strobe, then performs little-endian byte-lane extraction and sign/zero extension. Sits directly upstream of the ROM's data read port and downstream of the core's data-bus address decoder. Writes, misaligned accesses and out-of-range addresses complete with an error response without touching the ROM.

---
 rtl/urom_rd_adapter_if.sv | 31 +++
 rtl/urom_rd_adapter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/urom_rd_adapter_if.sv
// Bundle of the load/store-unit request/response signals and the ROM word read port
// seen by urom_rd_adapter.
interface urom_rd_adapter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            hb;
    logic                  is_unsigned;
    logic                  gnt;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  valid;
    logic                  err;
    logic                  urom_ce;
    logic [ADDR_WIDTH-1:0] urom_addr;
    logic [DATA_WIDTH-1:0] urom_rdata;
    logic                  urom_valid;

    // master: the core plus the ROM as seen from outside the adapter
    modport master (
        output req, we, addr, hb, is_unsigned, urom_rdata, urom_valid,
        input  gnt, rdata, valid, err, urom_ce, urom_addr
    );

    modport slave (
        input  req, we, addr, hb, is_unsigned, urom_rdata, urom_valid,
        output gnt, rdata, valid, err, urom_ce, urom_addr
    );
endinterface

// File: rtl/urom_rd_adapter.sv
// Byte-addressed read port onto the ROM's word read port: one request in flight,
// little-endian lane extraction with sign/zero extension, error response for illegal accesses.
module urom_rd_adapter #(
    parameter int unsigned           DATA_WIDTH = 32,  // only 32 is supported
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           UROM_DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input logic               i_CLK,
    input logic               i_RST,
    urom_rd_adapter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(UROM_DEPTH);

    logic [1:0]            state_q, state_d;
    logic [1:0]            off_q;
    logic [1:0]            hb_q;
    logic                  uns_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] urom_addr_q;

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  addr_low;
    logic                  idx_oob;
    logic                  misaligned;
    logic                  acc_err;
    logic                  accept;
    logic [7:0]            byte_f;
    logic [15:0]           half_f;
    logic [DATA_WIDTH-1:0] ext_data;

    // Range check on the unrebased address so a wrapped subtraction cannot look in range.
    assign offset   = bus.addr - BASE_ADDR;
    assign word_idx = offset >> 2;
    assign addr_low = bus.addr < BASE_ADDR;
    assign idx_oob  = word_idx >= DEPTH_W;

    always_comb begin
        misaligned = 1'b0;
        case (bus.hb)
            2'b01:   misaligned = bus.addr[0];
            2'b10:   misaligned = |bus.addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign acc_err = bus.we | (bus.hb == 2'b11) | misaligned | addr_low | idx_oob;
    assign accept  = bus.req && (state_q == ST_IDLE);

    always_comb begin
        byte_f = 8'h00;
        unique case (off_q)
            2'd0: byte_f = bus.urom_rdata[7:0];
            2'd1: byte_f = bus.urom_rdata[15:8];
            2'd2: byte_f = bus.urom_rdata[23:16];
            2'd3: byte_f = bus.urom_rdata[31:24];
        endcase
        half_f = off_q[1] ? bus.urom_rdata[31:16] : bus.urom_rdata[15:0];
        case (hb_q)
            2'b00:   ext_data = {{(DATA_WIDTH-8){byte_f[7] & ~uns_q}}, byte_f};
            2'b01:   ext_data = {{(DATA_WIDTH-16){half_f[15] & ~uns_q}}, half_f};
            default: ext_data = bus.urom_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = acc_err ? ST_RESP : ST_READ;
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: if (bus.urom_valid) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= ST_IDLE;
            off_q       <= 2'd0;
            hb_q        <= 2'd0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            urom_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                off_q <= bus.addr[1:0];
                hb_q  <= bus.hb;
                uns_q <= bus.is_unsigned;
                if (acc_err) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else begin
                    urom_addr_q <= word_idx;
                end
            end
            // Response registers change only when entering RESP so they hold otherwise.
            if ((state_q == ST_WAIT) && bus.urom_valid) begin
                err_q   <= 1'b0;
                rdata_q <= ext_data;
            end
        end
    end

    assign bus.gnt       = (state_q == ST_IDLE);
    assign bus.valid     = (state_q == ST_RESP);
    assign bus.urom_ce   = (state_q == ST_READ);
    assign bus.urom_addr = urom_addr_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;

endmodule
